lifo_arbiter: RTL and testbench
===============================

Name: lifo_arbiter

Overview:
Two-port arbiter and sequencer for the 16-bit hardware stack (lifo). It shares the stack between two requesters, for example CPU PUSH/POP decode (port 0) and a debug/DMA master (port 1). It serialises requests and drives lifo_en, lifo_mode and lifo data_i. It guards against push-when-full and pop-when-empty, and returns pop data through a per-port response pulse.

Parameters:
DATA_W, 16, stack word width; must match lifo data_i/data_o.
NPORT, 2, number of requesters; fixed at 2, the parameter exists for documentation and assertions only.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  2  per-port request valid (bit0 = port 0)
req_push  in  2  per-port op: 1 = push, 0 = pop
req_data  in  2*DATA_W  per-port push data, port 0 in [DATA_W-1:0]
req_ready  out  2  per-port accept; one-hot or zero
rsp_valid  out  2  per-port one-cycle response pulse
rsp_data  out  DATA_W  pop data (zero for push and for errors); shared, qualified by rsp_valid
rsp_err  out  1  response carries an error (overflow or underflow); qualified by rsp_valid
lifo_en  out  1  to lifo en
lifo_mode  out  1  to lifo mode: 1 = push, 0 = pop
lifo_wdata  out  DATA_W  to lifo data_i
lifo_rdata  in  DATA_W  from lifo data_o
lifo_full  in  1  from lifo full
lifo_empty  in  1  from lifo empty
err_clr  in  1  clears sticky error flags
err_ovf  out  1  sticky: a push was rejected because the stack was full
err_udf  out  1  sticky: a pop was rejected because the stack was empty

Behaviour:
- Reset (async, rst_n = 0) sets:
  - FSM = IDLE
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0
  - lifo_en = 0, lifo_mode = 0, lifo_wdata = 0
  - err_ovf = 0, err_udf = 0
  - round-robin pointer = port 0 preferred
- Reset asserted mid-operation aborts the operation. No response is issued, and lifo_en drops asynchronously.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. Throughput is one operation per 3 cycles.
- IDLE:
  - grant = arbiter(req_valid, pointer); req_ready[grant] = 1 combinationally, only in IDLE.
  - On a handshake (valid & ready), latch the port, op and data, then go to ISSUE.
  - The pointer moves to the non-granted port after each grant.
  - If only one port is valid, it wins regardless of the pointer.
- ISSUE (cycle 1 after accept):
  - Legal op (push & !lifo_full, or pop & !lifo_empty): lifo_en = 1 for exactly one cycle; lifo_mode = op; lifo_wdata = latched data.
  - Illegal op: lifo_en stays 0; set err_ovf (push) or err_udf (pop); mark the response as an error.
  - lifo_full and lifo_empty are sampled in ISSUE, not at accept.
- RESP (cycle 2 after accept):
  - rsp_valid[port] = 1 for one cycle.
  - rsp_data = lifo_rdata for a successful pop, 0 otherwise.
  - rsp_err = the error mark.
  - Return to IDLE; no new grant is issued in the RESP cycle.
- Outside ISSUE, lifo_en = 0. Outside RESP, rsp_valid = 0, and rsp_data/rsp_err hold their last values.
- Requesters must hold req_valid, req_push and req_data stable until ready. The arbiter never drops an accepted request.
- err_clr has priority below set: if err_clr and a new error occur in the same cycle, the flag remains 1.
- Data width: port data is DATA_W wide with no extension. The CPU side zero-extends rsp_data to 32 bits.

Optional Feature:
- Macro LIFO_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins when both ports are valid; the pointer logic is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared header sr_cpu.vh gains:
  - LIFO_MODE_PUSH = 1'b1, LIFO_MODE_POP = 1'b0
  - LARB_IDLE / LARB_ISSUE / LARB_RESP state encodings (2-bit)
- One sub-module, lifo_rr_arb2: the two-input grant, pointer register and the fixed-priority macro switch.
- The FSM, operation latch, legality check and error flags stay in lifo_arbiter.

Test Plan:
1. Reset, then port 0 pushes 0x1234 and later pops -> the push gives lifo_en = 1 with mode = 1 and wdata = 0x1234 at accept+1. The pop gives rsp_valid[0] = 1 with rsp_data = 0x1234 and rsp_err = 0 at accept+2.
2. Both ports valid continuously: port 0 pushes 0xA, port 1 pushes 0xB -> grants alternate 0, 1, 0, 1 every 3 cycles. With FIXED_PRIO_EN defined, port 0 gets every grant and port 1 starves.
3. Pop with lifo_empty = 1 -> lifo_en stays 0, rsp_err = 1, rsp_data = 0, err_udf = 1. Pulsing err_clr clears err_udf on the next edge.
4. Push with lifo_full = 1 -> no lifo_en, err_ovf = 1. Then err_clr together with a second full push -> err_ovf stays 1.
5. Accept a pop, then assert rst_n = 0 during ISSUE -> lifo_en = 0 immediately, no rsp_valid, FSM in IDLE, port 0 preferred after reset release.
6. Pop issued on the lifo with 3 entries 0x1, 0x2, 0x3 -> rsp_data sequence 0x3, 0x2, 0x1, then an error response on the 4th pop.

Source files
------------

// File: rtl/lifo_arbiter_pkg.sv
// rtl/lifo_arbiter_pkg.sv - shared state encodings and lifo mode constants for the lifo arbiter
package lifo_arbiter_pkg;

    typedef enum logic [1:0] {
        LARB_IDLE  = 2'd0,
        LARB_ISSUE = 2'd1,
        LARB_RESP  = 2'd2
    } larb_state_e;

    localparam logic LIFO_MODE_PUSH = 1'b1;
    localparam logic LIFO_MODE_POP  = 1'b0;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lifo_rr_arb2.sv
// rtl/lifo_rr_arb2.sv - two-input grant with round-robin pointer; LIFO_ARBITER_FIXED_PRIO_EN selects fixed priority
module lifo_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic       advance,
    output logic       grant_idx,
    output logic       grant_any
);

    assign grant_any = |req_valid;

`ifdef LIFO_ARBITER_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, advance};
    assign grant_idx = ~req_valid[0];
`else
    logic ptr_q;
    logic ptr_d;

    // ptr_q names the port preferred when both request; a lone requester wins outright.
    always_comb begin
        grant_idx = (&req_valid) ? ptr_q : req_valid[1];
        ptr_d     = advance ? ~grant_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/lifo_arbiter.sv
// rtl/lifo_arbiter.sv - two-port sequencer sharing one hardware stack; see lifo_rr_arb2 for LIFO_ARBITER_FIXED_PRIO_EN
module lifo_arbiter
    import lifo_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NPORT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        req_valid,
    input  logic [NPORT-1:0]        req_push,
    input  logic [NPORT*DATA_W-1:0] req_data,
    output logic [NPORT-1:0]        req_ready,
    output logic [NPORT-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    lifo_en,
    output logic                    lifo_mode,
    output logic [DATA_W-1:0]       lifo_wdata,
    input  logic [DATA_W-1:0]       lifo_rdata,
    input  logic                    lifo_full,
    input  logic                    lifo_empty,
    input  logic                    err_clr,
    output logic                    err_ovf,
    output logic                    err_udf
);

    larb_state_e        state_q, state_d;
    logic               port_q, port_d;
    logic               push_q, push_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_mark_q, err_mark_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_udf_q, err_udf_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               grant_idx, grant_any, advance;
    logic               op_legal, set_ovf, set_udf;
    logic [DATA_W-1:0]  pop_data;

    lifo_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .advance   (advance),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Fullness/emptiness are judged in ISSUE, after any earlier operation has landed.
    assign op_legal   = push_q ? !lifo_full : !lifo_empty;
    assign pop_data   = (push_q || err_mark_q) ? '0 : lifo_rdata;
    assign lifo_mode  = push_q;
    assign lifo_wdata = data_q;
    assign err_ovf    = err_ovf_q;
    assign err_udf    = err_udf_q;

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        push_d     = push_q;
        data_d     = data_q;
        err_mark_d = err_mark_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        advance    = 1'b0;
        req_ready  = '0;
        rsp_valid  = '0;
        lifo_en    = 1'b0;
        rsp_data   = rsp_data_q;
        rsp_err    = rsp_err_q;
        case (state_q)
            LARB_IDLE: begin
                // rst_n gating keeps ready low while reset holds the FSM in IDLE.
                if (grant_any && rst_n) begin
                    req_ready = port_onehot(grant_idx);
                    advance   = 1'b1;
                    port_d    = grant_idx;
                    push_d    = req_push[grant_idx];
                    data_d    = grant_idx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    state_d   = LARB_ISSUE;
                end
            end
            LARB_ISSUE: begin
                lifo_en    = op_legal;
                err_mark_d = !op_legal;
                set_ovf    = push_q && !op_legal;
                set_udf    = !push_q && !op_legal;
                state_d    = LARB_RESP;
            end
            LARB_RESP: begin
                rsp_valid  = port_onehot(port_q);
                rsp_data   = pop_data;
                rsp_err    = err_mark_q;
                rsp_data_d = pop_data;
                rsp_err_d  = err_mark_q;
                state_d    = LARB_IDLE;
            end
            default: state_d = LARB_IDLE;
        endcase
        err_ovf_d = set_ovf || (err_ovf_q && !err_clr);
        err_udf_d = set_udf || (err_udf_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LARB_IDLE;
            port_q     <= 1'b0;
            push_q     <= LIFO_MODE_POP;
            data_q     <= '0;
            err_mark_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            push_q     <= push_d;
            data_q     <= data_d;
            err_mark_q <= err_mark_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb/tb_lifo_arbiter.sv - scoreboard bench for lifo_arbiter with a behavioural stack and random two-port traffic
module tb_lifo_arbiter;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    rv = '0, rp = '0;
    logic [DW-1:0] rd0 = '0, rd1 = '0;
    logic          err_clr = 1'b0;
    logic [1:0]    req_ready, rsp_valid;
    logic [DW-1:0] rsp_data, lifo_wdata;
    logic [DW-1:0] lifo_rdata = '0;
    logic          rsp_err, lifo_en, lifo_mode, lifo_full, lifo_empty, err_ovf, err_udf;

    always #5 clk = ~clk;

    lifo_arbiter #(.DATA_W(DW), .NPORT(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_push(rp), .req_data({rd1, rd0}),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .lifo_en(lifo_en), .lifo_mode(lifo_mode), .lifo_wdata(lifo_wdata), .lifo_rdata(lifo_rdata),
        .lifo_full(lifo_full), .lifo_empty(lifo_empty), .err_clr(err_clr),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    // Stack the arbiter drives: data_o is registered on pop.
    logic [DW-1:0] env_stk[$];
    int            env_cnt = 0;
    always @(posedge clk) begin
        if (lifo_en) begin
            if (lifo_mode) env_stk.push_back(lifo_wdata);
            else if (env_stk.size() > 0) lifo_rdata <= env_stk.pop_back();
            else lifo_rdata <= 16'hDEAD;
            env_cnt = env_stk.size();
        end
    end
    assign lifo_full  = (env_cnt >= DEPTH);
    assign lifo_empty = (env_cnt == 0);

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;
    exp_t sb[$];

    // Reference: stack contents, preferred port, sticky flags, busy window.
    logic [DW-1:0] ref_stk[$];
    logic          pref = 1'b0;
    logic          m_ovf = 1'b0, m_udf = 1'b0;
    int            busy = 0;
    logic          iss_pend = 1'b0, iss_legal, iss_push;
    logic [DW-1:0] iss_data;
    logic [1:0]    acc_mask;

    always @(negedge clk) begin
        if (rst_n && rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", {30'd0, rsp_valid}, e.port ? 32'd2 : 32'd1);
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_latency", cyc, e.due);
            end
        end
    end

    task automatic step();
        logic [1:0]    exp_rdy;
        logic          g, ovf_n, udf_n, bad;
        logic [DW-1:0] d, r;
        @(negedge clk);
        chk("err_ovf", {31'd0, err_ovf}, {31'd0, m_ovf});
        chk("err_udf", {31'd0, err_udf}, {31'd0, m_udf});
        ovf_n = err_clr ? 1'b0 : m_ovf;
        udf_n = err_clr ? 1'b0 : m_udf;
        if (iss_pend) begin
            chk("lifo_en", {31'd0, lifo_en}, {31'd0, iss_legal});
            if (iss_legal) begin
                chk("lifo_mode", {31'd0, lifo_mode}, {31'd0, iss_push});
                if (iss_push) chk("lifo_wdata", {16'd0, lifo_wdata}, {16'd0, iss_data});
            end else if (iss_push) ovf_n = 1'b1;
            else udf_n = 1'b1;
            iss_pend = 1'b0;
        end else begin
            chk("lifo_en_idle", {31'd0, lifo_en}, 32'd0);
        end
        m_ovf = ovf_n;
        m_udf = udf_n;
        if (busy > 0) busy--;
        exp_rdy = 2'b00;
        g = 1'b0;
        if (busy == 0 && rv != 2'b00) begin
`ifdef LIFO_ARBITER_FIXED_PRIO_EN
            g = !rv[0];
`else
            g = (rv == 2'b11) ? pref : rv[1];
`endif
            exp_rdy = g ? 2'b10 : 2'b01;
        end
        chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        acc_mask = exp_rdy;
        if (exp_rdy != 2'b00) begin
            d = g ? rd1 : rd0;
            r = '0;
            bad = 1'b0;
            if (rp[g]) begin
                if (ref_stk.size() >= DEPTH) bad = 1'b1;
                else ref_stk.push_back(d);
            end else begin
                if (ref_stk.size() == 0) bad = 1'b1;
                else r = ref_stk.pop_back();
            end
            sb.push_back('{port: g, data: r, err: bad, due: cyc + 2});
            iss_pend = 1'b1;
            iss_legal = !bad;
            iss_push = rp[g];
            iss_data = d;
            busy = 3;
            pref = !g;
        end
    endtask

    task automatic adv();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic p, input logic push, input logic [DW-1:0] d, input logic clr);
        int t;
        rv[p] = 1'b1;
        rp[p] = push;
        if (p) rd1 = d; else rd0 = d;
        t = 0;
        do begin
            adv();
            t++;
        end while (!acc_mask[p] && t < 20);
        if (t >= 20) chk("accept_timeout", 32'd1, 32'd0);
        rv[p] = 1'b0;
        err_clr = clr;
        adv();
        err_clr = 1'b0;
        adv();
        adv();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_lifo_en", {31'd0, lifo_en}, 32'd0);
        chk("rst_lifo_mode", {31'd0, lifo_mode}, 32'd0);
        chk("rst_lifo_wdata", {16'd0, lifo_wdata}, 32'd0);
        chk("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
        chk("rst_err_udf", {31'd0, err_udf}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        adv();

        do_op(1'b0, 1'b1, 16'h1234, 1'b0);
        do_op(1'b0, 1'b0, 16'h0000, 1'b0);
        do_op(1'b0, 1'b0, 16'h0000, 1'b0);
        err_clr = 1'b1;
        adv();
        err_clr = 1'b0;
        adv();
        for (int i = 1; i <= 3; i++) do_op(1'b1, 1'b1, 16'(i), 1'b0);
        for (int i = 0; i < 4; i++) do_op(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) do_op(1'b0, 1'b1, 16'h00F0 + 16'(i), 1'b0);
        do_op(1'b1, 1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 16'h0000, 1'b0);

        rv = 2'b11; rp = 2'b11; rd0 = 16'h000A; rd1 = 16'h000B;
        repeat (12) adv();
        rp = 2'b00;
        repeat (15) adv();
        rv = 2'b00;
        repeat (4) adv();

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc_mask[p] || !rv[p]) begin
                    rv[p] = 1'($urandom_range(0, 1));
                    rp[p] = 1'($urandom_range(0, 1));
                    if (p == 1) rd1 = 16'($urandom);
                    else rd0 = 16'($urandom);
                end
            end
            err_clr = ($urandom_range(0, 7) == 0);
            adv();
        end
        rv = 2'b00;
        err_clr = 1'b0;
        repeat (4) adv();

        for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b0, 16'h0000, 1'b0);
        do_op(1'b0, 1'b1, 16'h0055, 1'b0);
        rv = 2'b01; rp = 2'b00;
        for (int t = 0; t < 20 && !acc_mask[0]; t++) adv();
        chk("issue_lifo_en", {31'd0, lifo_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_lifo_en", {31'd0, lifo_en}, 32'd0);
        chk("rst_async_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_async_req_ready", {30'd0, req_ready}, 32'd0);
        ref_stk.push_back(16'h0055);
        void'(sb.pop_back());
        busy = 0; iss_pend = 1'b0; pref = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        rv = 2'b00;
        @(negedge clk);
        chk("rst_hold_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rv = 2'b11; rp = 2'b00;
        adv();
        chk("post_rst_grant_port0", {31'd0, acc_mask[0]}, 32'd1);
        rv = 2'b10;
        repeat (3) adv();
        rv = 2'b00;
        repeat (5) adv();
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
